// File: rtl/irq_ctrl.sv
// Vectored, maskable, nesting-aware interrupt controller.
// Tracks pending, enabled and in-service sources and presents the highest eligible vector to the CPU.
module irq_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             p_reset_n,
    input  logic [15:0]      src,
    input  logic             io_wr,
    input  logic             io_rd,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq,
    output logic [3:0]       ivec,
    input  logic             iack
);

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_EN    = 2'd1;
    localparam logic [1:0] A_CLEAR = 2'd2;
    localparam logic [1:0] A_ISR   = 2'd3;

    logic [15:0] pend;
    logic [15:0] en;
    logic [15:0] isr;

    logic [3:0]  cand;
    logic [3:0]  cur;
    logic        wr_pend;
    logic        wr_en;
    logic        wr_clear;
    logic        wr_eoi;
    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    logic [15:0] ack_mask;
    logic [15:0] eoi_mask;
    logic [15:0] pend_nxt;
    logic [15:0] isr_nxt;
    logic [15:0] rd_data;

    // Register bits above 15 carry no state.
    logic unused_din_hi;
    assign unused_din_hi = ^din[WIDTH-1:16];

    assign wr_pend  = io_wr && (addr == A_PEND);
    assign wr_en    = io_wr && (addr == A_EN);
    assign wr_clear = io_wr && (addr == A_CLEAR);
    assign wr_eoi   = io_wr && (addr == A_ISR);

    // NOTE: every combinational output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        cand = 4'd0;
        cur  = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (pend[i] && en[i]) cand = 4'(i);
            if (isr[i])           cur  = 4'(i);
        end
    end

    // Only a strictly higher priority than the one in service may interrupt.
    assign ivec = (en[0] && (cand > cur)) ? cand : 4'd0;
    assign irq  = (ivec != 4'd0);

    always_comb begin
        ack_mask = (iack && irq) ? (16'd1 << ivec) : 16'd0;
        eoi_mask = (wr_eoi && (cur != 4'd0)) ? (16'd1 << cur) : 16'd0;
        set_mask = src | (wr_pend ? din[15:0] : 16'd0);
        clr_mask = ack_mask | (wr_clear ? din[15:0] : 16'd0);
        // Set wins over clear so a strobe coinciding with a clear or ack is never lost.
        pend_nxt = (set_mask | (pend & ~clr_mask)) & 16'hFFFE;
        isr_nxt  = (isr & ~eoi_mask) | ack_mask;
    end

    always_comb begin
        case (addr)
            A_PEND:  rd_data = pend;
            A_EN:    rd_data = en;
            A_CLEAR: rd_data = 16'd0;
            default: rd_data = isr;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            pend <= 16'd0;
            en   <= 16'd0;
            isr  <= 16'd0;
            dout <= '0;
        end else begin
            pend <= pend_nxt;
            isr  <= isr_nxt;
            if (wr_en) en <= din[15:0];
            if (io_rd) dout <= WIDTH'(rd_data);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, reset corner case,
// and randomized traffic compared against a rule-level reference model.
module tb_irq_ctrl;

    localparam int WIDTH = 24;

    logic             clk;
    logic             p_reset_n;
    logic [15:0]      src;
    logic             io_wr;
    logic             io_rd;
    logic [1:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq;
    logic [3:0]       ivec;
    logic             iack;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .p_reset_n (p_reset_n),
        .src       (src),
        .io_wr     (io_wr),
        .io_rd     (io_rd),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .irq       (irq),
        .ivec      (ivec),
        .iack      (iack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [23:0] din;
        logic [15:0] src;
        logic        iack;
        logic        exp_irq;
        logic [3:0]  exp_ivec;
        logic [23:0] exp_dout;
    } vec_t;

    vec_t vecs[36];

    // Reference model state
    logic [15:0]      m_pend;
    logic [15:0]      m_en;
    logic [15:0]      m_isr;
    logic [WIDTH-1:0] m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int highest(input logic [15:0] v);
        for (int i = 15; i >= 1; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic int model_ivec();
        int c;
        int u;
        c = highest(m_pend & m_en);
        u = highest(m_isr);
        return (m_en[0] && c > u) ? c : 0;
    endfunction

    task automatic model_reset();
        m_pend = 16'd0;
        m_en   = 16'd0;
        m_isr  = 16'd0;
        m_dout = '0;
    endtask

    task automatic model_clock(input logic wr, input logic rd, input logic [1:0] a,
                               input logic [23:0] d, input logic [15:0] s, input logic ack);
        int k;
        int u;
        logic [15:0] np;
        k = model_ivec();
        u = highest(m_isr);
        if (rd) begin
            case (a)
                2'd0: m_dout = WIDTH'(m_pend);
                2'd1: m_dout = WIDTH'(m_en);
                2'd2: m_dout = '0;
                default: m_dout = WIDTH'(m_isr);
            endcase
        end
        np = m_pend;
        if (wr && a == 2'd2) np = np & ~d[15:0];
        if (ack && k != 0) np[k] = 1'b0;
        np = np | s;
        if (wr && a == 2'd0) np = np | d[15:0];
        np[0] = 1'b0;
        m_pend = np;
        if (wr && a == 2'd3 && u != 0) m_isr[u] = 1'b0;
        if (ack && k != 0) m_isr[k] = 1'b1;
        if (wr && a == 2'd1) m_en = d[15:0];
    endtask

    // Drive one cycle of inputs, advance both DUT and model, compare on the falling edge.
    task automatic step(input logic wr, input logic rd, input logic [1:0] a,
                        input logic [23:0] d, input logic [15:0] s, input logic ack);
        int k;
        io_wr = wr;
        io_rd = rd;
        addr  = a;
        din   = d;
        src   = s;
        iack  = ack;
        @(posedge clk);
        model_clock(wr, rd, a, d, s, ack);
        @(negedge clk);
        k = model_ivec();
        check("model_irq",  32'(irq),  32'(k != 0));
        check("model_ivec", 32'(ivec), 32'(k));
        check("model_dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic idle_inputs();
        io_wr = 1'b0;
        io_rd = 1'b0;
        addr  = 2'd0;
        din   = '0;
        src   = 16'd0;
        iack  = 1'b0;
    endtask

    initial begin
        //          wr    rd    addr  din        src       iack  irq   ivec  dout
        vecs[0]  = '{1'b1, 1'b0, 2'd1, 24'h0009,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0008, 1'b0, 1'b1, 4'd3,  24'h0000};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0000, 1'b1, 1'b0, 4'd0,  24'h0000};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0008};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 24'h0049,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0040, 1'b0, 1'b1, 4'd6,  24'h0000};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0000, 1'b1, 1'b0, 4'd0,  24'h0000};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0048};
        vecs[9]  = '{1'b1, 1'b0, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0048};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0008};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0008};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[13] = '{1'b1, 1'b0, 2'd1, 24'h0031,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0030, 1'b0, 1'b1, 4'd5,  24'h0000};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0000, 1'b1, 1'b0, 4'd0,  24'h0000};
        vecs[16] = '{1'b1, 1'b0, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b1, 4'd4,  24'h0000};
        vecs[17] = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0000, 1'b1, 1'b0, 4'd0,  24'h0000};
        vecs[18] = '{1'b1, 1'b0, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[19] = '{1'b1, 1'b0, 2'd1, 24'h0004,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[20] = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0004, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[21] = '{1'b0, 1'b1, 2'd0, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0004};
        vecs[22] = '{1'b1, 1'b0, 2'd1, 24'h0005,  16'h0000, 1'b0, 1'b1, 4'd2,  24'h0004};
        vecs[23] = '{1'b1, 1'b0, 2'd2, 24'h0004,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0004};
        vecs[24] = '{1'b1, 1'b0, 2'd1, 24'h0011,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0004};
        vecs[25] = '{1'b1, 1'b0, 2'd2, 24'h0010,  16'h0010, 1'b0, 1'b1, 4'd4,  24'h0004};
        vecs[26] = '{1'b0, 1'b0, 2'd0, 24'h0000,  16'h0010, 1'b1, 1'b0, 4'd0,  24'h0004};
        vecs[27] = '{1'b0, 1'b1, 2'd0, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0010};
        vecs[28] = '{1'b0, 1'b1, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0010};
        vecs[29] = '{1'b0, 1'b1, 2'd2, 24'h0000,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[30] = '{1'b1, 1'b0, 2'd3, 24'h0000,  16'h0000, 1'b0, 1'b1, 4'd4,  24'h0000};
        vecs[31] = '{1'b1, 1'b0, 2'd2, 24'hFFFF,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[32] = '{1'b1, 1'b0, 2'd1, 24'h8001,  16'h0000, 1'b0, 1'b0, 4'd0,  24'h0000};
        vecs[33] = '{1'b1, 1'b0, 2'd0, 24'hFF8001, 16'h0000, 1'b0, 1'b1, 4'd15, 24'h0000};
        vecs[34] = '{1'b0, 1'b1, 2'd0, 24'h0000,  16'h0000, 1'b0, 1'b1, 4'd15, 24'h8000};
        vecs[35] = '{1'b0, 1'b1, 2'd1, 24'h0000,  16'h0000, 1'b0, 1'b1, 4'd15, 24'h8001};

        p_reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        check("reset_irq",  32'(irq),  32'd0);
        check("reset_ivec", 32'(ivec), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        p_reset_n = 1'b1;

        for (int i = 0; i < 36; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].src, vecs[i].iack);
            check($sformatf("vec%0d_irq", i),  32'(irq),  32'(vecs[i].exp_irq));
            check($sformatf("vec%0d_ivec", i), 32'(ivec), 32'(vecs[i].exp_ivec));
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
        end
        idle_inputs();

        // Reset asserted between edges while source 15 is requesting.
        #2;
        p_reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_irq",  32'(irq),  32'd0);
        check("midrst_ivec", 32'(ivec), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        p_reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 1'b1, 2'(a), 24'h0, 16'h0, 1'b0);
            check($sformatf("postrst_reg%0d", a), 32'(dout), 32'd0);
            check($sformatf("postrst_ivec%0d", a), 32'(ivec), 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic        r_wr;
            logic        r_rd;
            logic [1:0]  r_addr;
            logic [23:0] r_din;
            logic [15:0] r_src;
            logic        r_ack;
            r_wr   = ($urandom % 4) == 0;
            r_rd   = ($urandom % 3) == 0;
            r_addr = 2'($urandom);
            r_din  = 24'($urandom);
            if (r_wr && r_addr == 2'd1 && ($urandom % 4) != 0) r_din[0] = 1'b1;
            r_src  = 16'($urandom & $urandom & $urandom);
            if (model_ivec() != 0) r_ack = ($urandom % 2) == 0;
            else                   r_ack = ($urandom % 8) == 0;
            step(r_wr, r_rd, r_addr, r_din, r_src, r_ack);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
